// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and default parameters for the immediate extension stage
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;

  localparam int WL_DEF       = 32;
  localparam int IW_DEF       = 16;
  localparam int BR_SHIFT_DEF = 2;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate widening; IMMEXT_BRANCH_EN enables the branch-offset shifter
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int WL       = WL_DEF,
  parameter int IW       = IW_DEF,
  parameter int BR_SHIFT = BR_SHIFT_DEF
) (
  input  logic [IW-1:0] imm,
  input  logic [1:0]    mode,
  output logic [WL-1:0] ext,
  output logic          err
);

  generate
    if (BR_SHIFT < 0 || BR_SHIFT >= WL) begin : g_bad_shift
      $error("imm_ext_core: BR_SHIFT must satisfy 0 <= BR_SHIFT < WL");
    end
  endgenerate

  logic [WL-1:0] sext;
  logic [WL-1:0] zext;
  logic [WL-1:0] uext;

  assign sext = {{(WL-IW){imm[IW-1]}}, imm};
  assign zext = {{(WL-IW){1'b0}}, imm};
  assign uext = {imm, {(WL-IW){1'b0}}};

  // Select the widened value for the requested mode; without the branch
  // feature mode 11 falls back to sign extension and is flagged.
  always_comb begin
    ext = sext;
    err = 1'b0;
    case (ext_mode_t'(mode))
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = zext;
      EXT_UPPER:  ext = uext;
`ifdef IMMEXT_BRANCH_EN
      EXT_BRANCH: ext = sext << BR_SHIFT;
`else
      EXT_BRANCH: begin
        ext = sext;
        err = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extension with two-entry skid buffer (IMMEXT_BRANCH_EN selects branch mode)
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int WL       = WL_DEF,
  parameter int IW       = IW_DEF,
  parameter int BR_SHIFT = BR_SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] imm,
  input  logic [1:0]    mode,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] ext,
  output logic          out_err
);

  generate
    if (WL <= IW) begin : g_bad_width
      $error("imm_extend_pipe: WL must be greater than IW");
    end
  endgenerate

  logic [WL-1:0] core_ext;
  logic          core_err;

  imm_ext_core #(
    .WL       (WL),
    .IW       (IW),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .imm  (imm),
    .mode (mode),
    .ext  (core_ext),
    .err  (core_err)
  );

  logic          main_valid;
  logic [WL-1:0] main_ext;
  logic          main_err;
  logic          skid_valid;
  logic [WL-1:0] skid_ext;
  logic          skid_err;

  logic accept;
  logic drain;

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  assign ext       = main_ext;
  assign out_err   = main_err;

  // Main/skid register control: flush beats everything, skid refills main on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ext   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_ext   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_ext   <= skid_ext;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_ext <= core_ext;
        main_err <= core_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_ext   <= core_ext;
        main_err   <= core_err;
      end else begin
        skid_valid <= 1'b1;
        skid_ext   <= core_ext;
        skid_err   <= core_err;
      end
    end
  end

endmodule
